// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer: FSM states and the queued command word.
package i2c_pkg;

  localparam int DEV_ADDR_W = 7;
  localparam int REG_ADDR_W = 8;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } seq_state_t;

  typedef struct packed {
    logic                  read;
    logic [DEV_ADDR_W-1:0] dev_addr;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     wr_data;
  } i2c_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_o == CW'(DEPTH));
  assign empty_o   = (count_o == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues I2C register commands and plays them one at a time into basic_i2c_master,
// returning one response (read data / timeout flag) per command in order.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int DEV_ADDR_WIDTH     = DEV_ADDR_W,
  parameter int DEV_REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH         = DATA_W,
  parameter int FIFO_DEPTH         = 4,
  parameter int START_TIMEOUT      = 16,
  parameter int XFER_TIMEOUT       = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_read_i,
  input  logic [DEV_ADDR_WIDTH-1:0]     cmd_dev_addr_i,
  input  logic [DEV_REG_ADDR_WIDTH-1:0] cmd_reg_addr_i,
  input  logic [DATA_WIDTH-1:0]         cmd_wr_data_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          m_start_trans_o,
  output logic                          m_read_o,
  output logic [DEV_ADDR_WIDTH-1:0]     m_dev_addr_o,
  output logic [DEV_REG_ADDR_WIDTH-1:0] m_dev_reg_addr_o,
  output logic [DATA_WIDTH-1:0]         m_wr_data_o,
  input  logic [DATA_WIDTH-1:0]         m_read_data_i,
  input  logic                          m_busy_i,
  output logic                          idle_o
);

  localparam int CMD_W  = 1 + DEV_ADDR_WIDTH + DEV_REG_ADDR_WIDTH + DATA_WIDTH;
  localparam int MAX_TO = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
  localparam int TW     = $clog2(MAX_TO);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_SAT    = '1;

  seq_state_t       state;
  logic [TW-1:0]    timer;
  logic [CMD_W-1:0] fifo_wr_data;
  logic [CMD_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             fifo_push;
  logic             fifo_pop;

  assign fifo_wr_data = {cmd_read_i, cmd_dev_addr_i, cmd_reg_addr_i, cmd_wr_data_i};
  assign fifo_push    = cmd_valid_i && cmd_ready_o;
  // A master still busy from an aborted transfer holds the next command in the FIFO.
  assign fifo_pop     = (state == IDLE) && !fifo_empty && !m_busy_i;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (fifo_push),
    .wr_data_i (fifo_wr_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign cmd_ready_o     = !fifo_full;
  assign m_start_trans_o = (state == ISSUE);
  assign rsp_valid_o     = (state == RESP);
  assign idle_o          = (fifo_count == '0) && (state == IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      timer            <= '0;
      m_read_o         <= 1'b0;
      m_dev_addr_o     <= '0;
      m_dev_reg_addr_o <= '0;
      m_wr_data_o      <= '0;
      rsp_data_o       <= '0;
      rsp_err_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            m_read_o         <= fifo_head[CMD_W-1];
            m_dev_addr_o     <= fifo_head[CMD_W-2 -: DEV_ADDR_WIDTH];
            m_dev_reg_addr_o <= fifo_head[DATA_WIDTH +: DEV_REG_ADDR_WIDTH];
            m_wr_data_o      <= fifo_head[DATA_WIDTH-1:0];
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (m_busy_i) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (timer == START_LAST) begin
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b1;
            state      <= RESP;
          end else if (timer != TMR_SAT) begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!m_busy_i) begin
            rsp_data_o <= m_read_o ? m_read_data_i : '0;
            rsp_err_o  <= 1'b0;
            state      <= RESP;
          end else if (timer == XFER_LAST) begin
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b1;
            state      <= RESP;
          end else if (timer != TMR_SAT) begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer with a simple behavioural I2C master model.
module tb_i2c_cmd_sequencer;

  localparam int START_TIMEOUT = 16;

  typedef struct {
    logic       rd;
    logic [6:0] dev;
    logic [7:0] ra;
    logic [7:0] wd;
  } cmd_t;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  logic       tb_clk;
  logic       rst_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic       cmd_read_i;
  logic [6:0] cmd_dev_addr_i;
  logic [7:0] cmd_reg_addr_i;
  logic [7:0] cmd_wr_data_i;
  logic       rsp_valid_o;
  logic       rsp_ready_i;
  logic [7:0] rsp_data_o;
  logic       rsp_err_o;
  logic       m_start_trans_o;
  logic       m_read_o;
  logic [6:0] m_dev_addr_o;
  logic [7:0] m_dev_reg_addr_o;
  logic [7:0] m_wr_data_o;
  logic [7:0] m_read_data_i;
  logic       m_busy_i;
  logic       idle_o;

  logic slave_busy;
  logic busy_force;
  logic no_busy;
  logic rsp_prev;

  int n_checks;
  int n_errors;
  int n_cmds;
  int n_pulses;
  int cyc;
  int t_start;
  int t_rsp;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  assign m_busy_i = slave_busy | busy_force;

  i2c_cmd_sequencer #(
    .DEV_ADDR_WIDTH     (7),
    .DEV_REG_ADDR_WIDTH (8),
    .DATA_WIDTH         (8),
    .FIFO_DEPTH         (4),
    .START_TIMEOUT      (START_TIMEOUT),
    .XFER_TIMEOUT       (4096)
  ) dut (
    .clk_i            (tb_clk),
    .rst_i            (rst_i),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_read_i       (cmd_read_i),
    .cmd_dev_addr_i   (cmd_dev_addr_i),
    .cmd_reg_addr_i   (cmd_reg_addr_i),
    .cmd_wr_data_i    (cmd_wr_data_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o),
    .rsp_err_o        (rsp_err_o),
    .m_start_trans_o  (m_start_trans_o),
    .m_read_o         (m_read_o),
    .m_dev_addr_o     (m_dev_addr_o),
    .m_dev_reg_addr_o (m_dev_reg_addr_o),
    .m_wr_data_o      (m_wr_data_o),
    .m_read_data_i    (m_read_data_i),
    .m_busy_i         (m_busy_i),
    .idle_o           (idle_o)
  );

  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge tb_clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Master model: busy rises 2 cycles after the start pulse, drops 4 cycles later
  // with read data derived from the register address (also driven for writes).
  initial begin
    cmd_t c;
    slave_busy    = 1'b0;
    m_read_data_i = 8'h00;
    n_pulses      = 0;
    forever begin
      @(posedge tb_clk);
      #1;
      if (m_start_trans_o) begin
        n_pulses++;
        t_start = cyc;
        if (cmd_q.size() == 0) begin
          check("start_unexpected", 32'd1, 32'd0);
        end else begin
          c = cmd_q.pop_front();
          check("m_read", 32'(m_read_o), 32'(c.rd));
          check("m_dev_addr", 32'(m_dev_addr_o), 32'(c.dev));
          check("m_reg_addr", 32'(m_dev_reg_addr_o), 32'(c.ra));
          check("m_wr_data", 32'(m_wr_data_o), 32'(c.wd));
        end
        @(posedge tb_clk);
        #1;
        check("start_one_cycle", 32'(m_start_trans_o), 32'd0);
        if (!no_busy) begin
          @(posedge tb_clk);
          #1;
          slave_busy = 1'b1;
          repeat (4) @(posedge tb_clk);
          #1;
          m_read_data_i = m_dev_reg_addr_o ^ 8'h2C;
          slave_busy    = 1'b0;
        end
      end
    end
  end

  initial begin
    rsp_t e;
    rsp_prev = 1'b0;
    t_rsp    = 0;
    forever begin
      @(negedge tb_clk);
      if (rsp_valid_o && !rsp_prev) t_rsp = cyc;
      rsp_prev = rsp_valid_o;
      if (rsp_valid_o && rsp_ready_i) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_data", 32'(rsp_data_o), 32'(e.data));
          check("rsp_err", 32'(rsp_err_o), 32'(e.err));
        end
      end
    end
  end

  task automatic send_cmd(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [7:0] wd);
    bit   ok;
    rsp_t e;
    ok             = 1'b0;
    cmd_read_i     = rd;
    cmd_dev_addr_i = dev;
    cmd_reg_addr_i = ra;
    cmd_wr_data_i  = wd;
    cmd_valid_i    = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge tb_clk);
      if (cmd_ready_o) ok = 1'b1;
      @(posedge tb_clk);
      #1;
    end
    cmd_valid_i = 1'b0;
    if (!ok) begin
      check("cmd_accept_timeout", 32'd0, 32'd1);
    end else begin
      n_cmds++;
      cmd_q.push_back('{rd, dev, ra, wd});
      e.err  = no_busy;
      e.data = (rd && !no_busy) ? (ra ^ 8'h2C) : 8'h00;
      rsp_q.push_back(e);
    end
  endtask

  task automatic drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(posedge tb_clk);
      #1;
      if (rsp_q.size() == 0 && idle_o) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  initial begin
    int         p0;
    int         unstable;
    bit         seen;
    logic [7:0] hold_data;
    logic       hold_err;

    n_checks       = 0;
    n_errors       = 0;
    n_cmds         = 0;
    rst_i          = 1'b1;
    cmd_valid_i    = 1'b0;
    cmd_read_i     = 1'b0;
    cmd_dev_addr_i = '0;
    cmd_reg_addr_i = '0;
    cmd_wr_data_i  = '0;
    rsp_ready_i    = 1'b1;
    busy_force     = 1'b0;
    no_busy        = 1'b0;

    wait_cycles(3);
    check("rst_idle", 32'(idle_o), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_start", 32'(m_start_trans_o), 32'd0);
    check("rst_m_dev_addr", 32'(m_dev_addr_o), 32'd0);
    rst_i = 1'b0;
    wait_cycles(1);

    send_cmd(1'b0, 7'h55, 8'hAA, 8'hFF);
    drain(100);

    send_cmd(1'b1, 7'h55, 8'h10, 8'h00);
    drain(100);

    // Five back-to-back commands into a 4-deep FIFO: one drains into the FSM, four remain.
    send_cmd(1'b0, 7'h12, 8'h01, 8'h11);
    send_cmd(1'b1, 7'h13, 8'h02, 8'h00);
    send_cmd(1'b0, 7'h14, 8'h03, 8'h33);
    send_cmd(1'b1, 7'h15, 8'h04, 8'h00);
    send_cmd(1'b0, 7'h16, 8'h05, 8'h55);
    check("ready_full", 32'(cmd_ready_o), 32'd0);
    drain(400);
    check("ready_after_drain", 32'(cmd_ready_o), 32'd1);

    // No busy from the master: pulse cycle, START_TIMEOUT wait cycles, then response.
    no_busy = 1'b1;
    send_cmd(1'b1, 7'h55, 8'h10, 8'h00);
    drain(100);
    check("timeout_latency", 32'(t_rsp - t_start), 32'(START_TIMEOUT + 1));
    no_busy = 1'b0;

    rsp_ready_i = 1'b0;
    p0 = n_pulses;
    send_cmd(1'b1, 7'h21, 8'h31, 8'h00);
    send_cmd(1'b1, 7'h22, 8'h32, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      wait_cycles(1);
      if (rsp_valid_o) seen = 1'b1;
    end
    check("hold_rsp_seen", 32'(seen), 32'd1);
    hold_data = rsp_data_o;
    hold_err  = rsp_err_o;
    unstable  = 0;
    repeat (20) begin
      wait_cycles(1);
      if (!rsp_valid_o || rsp_data_o !== hold_data || rsp_err_o !== hold_err) unstable++;
    end
    check("hold_stable", 32'(unstable), 32'd0);
    check("hold_held_data", 32'(hold_data), 32'h1D);
    check("hold_single_start", 32'(n_pulses - p0), 32'd1);
    rsp_ready_i = 1'b1;
    drain(200);

    busy_force = 1'b1;
    p0 = n_pulses;
    send_cmd(1'b0, 7'h33, 8'h44, 8'h66);
    wait_cycles(12);
    check("busy_blocks_issue", 32'(n_pulses - p0), 32'd0);
    check("busy_not_idle", 32'(idle_o), 32'd0);
    busy_force = 1'b0;
    drain(100);
    check("busy_release_issue", 32'(n_pulses - p0), 32'd1);

    send_cmd(1'b1, 7'h60, 8'h70, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      wait_cycles(1);
      if (slave_busy) seen = 1'b1;
    end
    check("rst_test_busy_seen", 32'(seen), 32'd1);
    wait_cycles(1);
    rst_i = 1'b1;
    rsp_q.delete();
    cmd_q.delete();
    wait_cycles(1);
    rst_i = 1'b0;
    check("midrst_idle", 32'(idle_o), 32'd1);
    check("midrst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      wait_cycles(1);
      if (!slave_busy) seen = 1'b1;
    end
    wait_cycles(5);
    check("midrst_stays_idle", 32'(idle_o), 32'd1);

    check("pulse_count", 32'(n_pulses), 32'(n_cmds));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
